fetch_unit: RTL

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit.sv | 120 ++++++++++++
 1 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch unit: issues one word-aligned fetch at a time and holds the
// returned instruction with its pc and pc+4 until downstream consumes it.
// Ports: clk_i/rst_i; imem_req_* and imem_resp_* to memory; instr_o/pc_o/
// pc_plus4_o/valid_o/ready_i to the decoder; redirect_i/redirect_pc_i from branch logic.
// Latency: response in cycle N+k gives valid_o in N+k+1; backpressure holds outputs stable.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    output logic        imem_req_valid_o,
    input  logic        imem_req_ready_i,
    output logic [31:0] imem_addr_o,
    input  logic        imem_resp_valid_i,
    input  logic [31:0] imem_resp_data_i,
    output logic [31:0] instr_o,
    output logic [31:0] pc_o,
    output logic [31:0] pc_plus4_o,
    output logic        valid_o,
    input  logic        ready_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i
);

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2,
        S_DROP = 2'd3
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [31:0] pc;
    logic [31:0] pc_nxt;
    logic [31:0] redirect_target;
    logic        latch_resp;

    // Branch targets are forced to word alignment; low bits are ignored.
    assign redirect_target = {redirect_pc_i[31:2], 2'b00};
    assign imem_addr_o     = pc;

    always_comb begin
        state_nxt        = state;
        pc_nxt           = pc;
        imem_req_valid_o = 1'b0;
        valid_o          = 1'b0;
        latch_resp       = 1'b0;
        case (state)
            S_REQ: begin
                // A redirect in the same cycle suppresses the request so the
                // stale address never reaches memory.
                imem_req_valid_o = !redirect_i;
                if (redirect_i) begin
                    pc_nxt = redirect_target;
                end else if (imem_req_ready_i) begin
                    state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (redirect_i) begin
                    pc_nxt = redirect_target;
                    // If the response lands this cycle it is simply dropped;
                    // otherwise it is still in flight and must be swallowed.
                    state_nxt = imem_resp_valid_i ? S_REQ : S_DROP;
                end else if (imem_resp_valid_i) begin
                    latch_resp = 1'b1;
                    state_nxt  = S_HOLD;
                end
            end
            S_HOLD: begin
                valid_o = 1'b1;
                if (redirect_i) begin
                    // Held instruction is on the wrong path: discard it even
                    // if the decoder is ready this cycle.
                    pc_nxt    = redirect_target;
                    state_nxt = S_REQ;
                end else if (ready_i) begin
                    pc_nxt    = pc + 32'd4;
                    state_nxt = S_REQ;
                end
            end
            S_DROP: begin
                if (redirect_i) begin
                    pc_nxt = redirect_target;
                end else if (imem_resp_valid_i) begin
                    state_nxt = S_REQ;
                end
            end
            default: begin
                state_nxt = S_REQ;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= S_REQ;
            pc    <= RESET_PC;
        end else begin
            state <= state_nxt;
            pc    <= pc_nxt;
        end
    end

    // Decoder-facing registers only change on a captured response, so they
    // remain stable for the whole time valid_o is held under backpressure.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            instr_o    <= 32'd0;
            pc_o       <= 32'd0;
            pc_plus4_o <= 32'd0;
        end else if (latch_resp) begin
            instr_o    <= imem_resp_data_i;
            pc_o       <= pc;
            pc_plus4_o <= pc + 32'd4;
        end
    end

endmodule
